// File: rtl/boreal_pkg.sv
// rtl/boreal_pkg.sv - shared constants and types for the boreal gate blocks
package boreal_pkg;

  localparam logic [1:0] GATE_RSN_OK     = 2'd0;
  localparam logic [1:0] GATE_RSN_HASH   = 2'd1;
  localparam logic [1:0] GATE_RSN_TARGET = 2'd2;
  localparam logic [1:0] GATE_RSN_RATE   = 2'd3;

  localparam int GATE_OVR_BYPASS_BIT = 0;

  typedef enum logic [1:0] {
    GATE_ST_IDLE  = 2'd0,
    GATE_ST_CHECK = 2'd1,
    GATE_ST_RESP  = 2'd2
  } gate_state_t;

endpackage

// File: rtl/boreal_gate_rate_window.sv
// rtl/boreal_gate_rate_window.sv - free-running rate window and per-window grant count
module boreal_gate_rate_window (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant_pulse,
  input  logic [31:0] rate_window,
  output logic [31:0] win_count
);

  logic [31:0] cyc_cnt;
  logic        wrap;

  // >= rather than == so a window shortened below the current count wraps next cycle
  always_comb begin
    wrap = (rate_window > 32'd1) && (cyc_cnt >= (rate_window - 32'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= 32'd0;
      win_count <= 32'd0;
    end else begin
      if (rate_window <= 32'd1 || wrap) begin
        cyc_cnt <= 32'd0;
      end else begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end

      if (wrap) begin
        win_count <= grant_pulse ? 32'd1 : 32'd0;
      end else if (grant_pulse && win_count != 32'hFFFF_FFFF) begin
        win_count <= win_count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/boreal_gate_enforcer.sv
// rtl/boreal_gate_enforcer.sv - commit request grant/deny decision stage
module boreal_gate_enforcer
  import boreal_pkg::*;
#(
  parameter int          TGT_W     = 6,
  parameter logic [31:0] NONCE_RST = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TGT_W-1:0] req_target,
  input  logic [31:0]      req_hash,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_grant,
  output logic [1:0]       rsp_reason,
  output logic [31:0]      rsp_nonce,
  input  logic [31:0]      allow0,
  input  logic [31:0]      allow1,
  input  logic [31:0]      rate_limit,
  input  logic [31:0]      rate_window,
  input  logic [31:0]      policy_hash,
  input  logic [31:0]      override_reg,
  output logic [31:0]      nonce_val,
  output logic [31:0]      win_count
);

  gate_state_t      state, state_nxt;
  logic [TGT_W-1:0] tgt_q;
  logic [31:0]      hash_q;
  logic [63:0]      allow_vec;
  logic             bypass;
  logic             grant_dec;
  logic [1:0]       rsn_dec;
  logic             grant_pulse;
  logic             unused_ovr;

  assign allow_vec   = {allow1, allow0};
  assign bypass      = override_reg[GATE_OVR_BYPASS_BIT];
  assign unused_ovr  = ^override_reg[31:1];
  assign grant_pulse = (state == GATE_ST_CHECK) && grant_dec;

  always_comb begin
    state_nxt = state;
    grant_dec = 1'b0;
    rsn_dec   = GATE_RSN_OK;

    // Hash check is never bypassed; the other checks fall away under override
    if (hash_q != policy_hash) begin
      rsn_dec = GATE_RSN_HASH;
    end else if (!bypass && !allow_vec[tgt_q]) begin
      rsn_dec = GATE_RSN_TARGET;
    end else if (!bypass && (win_count >= rate_limit)) begin
      rsn_dec = GATE_RSN_RATE;
    end else begin
      grant_dec = 1'b1;
    end

    case (state)
      GATE_ST_IDLE:  if (req_valid && req_ready) state_nxt = GATE_ST_CHECK;
      GATE_ST_CHECK: state_nxt = GATE_ST_RESP;
      GATE_ST_RESP:  if (rsp_ready) state_nxt = GATE_ST_IDLE;
      default:       state_nxt = GATE_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GATE_ST_IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_grant  <= 1'b0;
      rsp_reason <= GATE_RSN_OK;
      rsp_nonce  <= 32'd0;
      nonce_val  <= NONCE_RST;
      tgt_q      <= '0;
      hash_q     <= 32'd0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == GATE_ST_IDLE);
      rsp_valid <= (state_nxt == GATE_ST_RESP);
      if (state == GATE_ST_IDLE && req_valid && req_ready) begin
        tgt_q  <= req_target;
        hash_q <= req_hash;
      end
      if (state == GATE_ST_CHECK) begin
        rsp_grant  <= grant_dec;
        rsp_reason <= rsn_dec;
        rsp_nonce  <= grant_dec ? nonce_val : 32'd0;
        if (grant_dec) nonce_val <= nonce_val + 32'd1;
      end
    end
  end

  boreal_gate_rate_window u_rate_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_pulse (grant_pulse),
    .rate_window (rate_window),
    .win_count   (win_count)
  );

endmodule

// File: tb/tb_boreal_gate_enforcer.sv
// tb/tb_boreal_gate_enforcer.sv - directed self-checking bench for boreal_gate_enforcer
module tb_boreal_gate_enforcer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  req_target = '0;
  logic [31:0] req_hash = '0;
  logic        rsp_ready = 1'b1;
  logic [31:0] allow0 = '0, allow1 = '0, rate_limit = '0, rate_window = '0;
  logic [31:0] policy_hash = '0, override_reg = '0;

  logic        req_ready, rsp_valid, rsp_grant;
  logic [1:0]  rsp_reason;
  logic [31:0] rsp_nonce, nonce_val, win_count;
  logic        req_ready_w, rsp_valid_w, rsp_grant_w;
  logic [1:0]  rsp_reason_w;
  logic [31:0] rsp_nonce_w, nonce_val_w, win_count_w;

  int n_vec = 0;
  int n_err = 0;

  logic        r_grant;
  logic [1:0]  r_reason;
  logic [31:0] r_nonce, r_nonce_w;
  int          r_lat;

  always #5 clk = ~clk;

  boreal_gate_enforcer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_hash(req_hash), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_grant(rsp_grant), .rsp_reason(rsp_reason),
    .rsp_nonce(rsp_nonce), .allow0(allow0), .allow1(allow1),
    .rate_limit(rate_limit), .rate_window(rate_window), .policy_hash(policy_hash),
    .override_reg(override_reg), .nonce_val(nonce_val), .win_count(win_count)
  );

  boreal_gate_enforcer #(.NONCE_RST(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_target(req_target), .req_hash(req_hash), .rsp_valid(rsp_valid_w),
    .rsp_ready(rsp_ready), .rsp_grant(rsp_grant_w), .rsp_reason(rsp_reason_w),
    .rsp_nonce(rsp_nonce_w), .allow0(allow0), .allow1(allow1),
    .rate_limit(rate_limit), .rate_window(rate_window), .policy_hash(policy_hash),
    .override_reg(override_reg), .nonce_val(nonce_val_w), .win_count(win_count_w)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issues one request and captures the response; rsp_ready must be high
  task automatic do_req(input logic [5:0] t, input logic [31:0] h);
    int k;
    k = 0;
    while (!req_ready && k < 10) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; req_target = t; req_hash = h;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 1;
    while (!rsp_valid && r_lat < 20) begin
      @(posedge clk); #1; r_lat++;
    end
    if (!rsp_valid) begin
      n_vec++; n_err++;
      $display("FAIL do_req_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
    r_grant = rsp_grant; r_reason = rsp_reason; r_nonce = rsp_nonce; r_nonce_w = rsp_nonce_w;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_grant, rsp_reason} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: rdy=%0b vld=%0b grant=%0b rsn=%0d required all 0",
               req_ready, rsp_valid, rsp_grant, rsp_reason);
    end
    n_vec++;
    if (rsp_nonce !== 32'd0 || nonce_val !== 32'd1 || win_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_regs: rsp_nonce=%h nonce=%h win=%h required 0/1/0",
               rsp_nonce, nonce_val, win_count);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_ready: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_grant_deny();
    apply_reset();
    allow0 = 32'h0000_0004; allow1 = 32'd0; policy_hash = 32'hABCD;
    rate_limit = 32'hFFFF_FFFF; rate_window = 32'd0; override_reg = 32'd0;
    do_req(6'd2, 32'hABCD);
    n_vec++;
    if (r_grant !== 1'b1 || r_reason !== 2'd0 || r_nonce !== 32'd1 || nonce_val !== 32'd2) begin
      n_err++;
      $display("FAIL grant_basic: grant=%0b rsn=%0d nonce=%h nonce_val=%h required 1/0/1/2",
               r_grant, r_reason, r_nonce, nonce_val);
    end
    n_vec++;
    if (r_lat !== 2) begin
      n_err++;
      $display("FAIL grant_latency: got %0d cycles required 2", r_lat);
    end
    do_req(6'd3, 32'hABCD);
    n_vec++;
    if (r_grant !== 1'b0 || r_reason !== 2'd2 || r_nonce !== 32'd0 || nonce_val !== 32'd2) begin
      n_err++;
      $display("FAIL deny_target: grant=%0b rsn=%0d nonce=%h nonce_val=%h required 0/2/0/2",
               r_grant, r_reason, r_nonce, nonce_val);
    end
    override_reg = 32'd1;
    do_req(6'd2, 32'h1234);
    n_vec++;
    if (r_grant !== 1'b0 || r_reason !== 2'd1 || nonce_val !== 32'd2) begin
      n_err++;
      $display("FAIL hash_beats_override: grant=%0b rsn=%0d nonce_val=%h required 0/1/2",
               r_grant, r_reason, nonce_val);
    end
    override_reg = 32'd0;
  endtask

  task automatic test_rate_window();
    logic [1:0] exp_rsn [3];
    int k;
    exp_rsn[0] = 2'd0; exp_rsn[1] = 2'd0; exp_rsn[2] = 2'd3;
    apply_reset();
    allow0 = 32'h0000_0004; policy_hash = 32'hABCD; override_reg = 32'd0;
    rate_limit = 32'd2; rate_window = 32'd100;
    for (int i = 0; i < 3; i++) begin
      do_req(6'd2, 32'hABCD);
      n_vec++;
      if (r_reason !== exp_rsn[i] || r_grant !== (exp_rsn[i] == 2'd0)) begin
        n_err++;
        $display("FAIL rate_seq[%0d]: grant=%0b rsn=%0d required rsn %0d", i, r_grant, r_reason, exp_rsn[i]);
      end
    end
    n_vec++;
    if (win_count !== 32'd2) begin
      n_err++;
      $display("FAIL rate_win_full: win_count=%0d required 2", win_count);
    end
    k = 0;
    while (win_count !== 32'd0 && k < 250) begin
      @(posedge clk); #1; k++;
    end
    n_vec++;
    if (win_count !== 32'd0) begin
      n_err++;
      $display("FAIL rate_win_clear: win_count=%0d required 0", win_count);
    end
    do_req(6'd2, 32'hABCD);
    n_vec++;
    if (r_grant !== 1'b1 || win_count !== 32'd1) begin
      n_err++;
      $display("FAIL rate_after_wrap: grant=%0b win=%0d required 1/1", r_grant, win_count);
    end
  endtask

  task automatic test_override();
    apply_reset();
    allow0 = 32'd0; allow1 = 32'd0; rate_limit = 32'd0; rate_window = 32'd0;
    policy_hash = 32'h5555; override_reg = 32'd1;
    do_req(6'd40, 32'h5555);
    n_vec++;
    if (r_grant !== 1'b1 || r_nonce !== 32'd1 || win_count !== 32'd1) begin
      n_err++;
      $display("FAIL override_grant: grant=%0b nonce=%h win=%0d required 1/1/1", r_grant, r_nonce, win_count);
    end
    override_reg = 32'd0; rate_limit = 32'd2;
    do_req(6'd40, 32'h5555);
    n_vec++;
    if (r_grant !== 1'b0 || r_reason !== 2'd2) begin
      n_err++;
      $display("FAIL allow1_denied: grant=%0b rsn=%0d required 0/2", r_grant, r_reason);
    end
    allow1 = 32'h0000_0100;
    do_req(6'd40, 32'h5555);
    n_vec++;
    if (r_grant !== 1'b1 || r_nonce !== 32'd2 || win_count !== 32'd2) begin
      n_err++;
      $display("FAIL allow1_grant: grant=%0b nonce=%h win=%0d required 1/2/2", r_grant, r_nonce, win_count);
    end
    do_req(6'd40, 32'h5555);
    n_vec++;
    if (r_grant !== 1'b0 || r_reason !== 2'd3 || win_count !== 32'd2) begin
      n_err++;
      $display("FAIL allow1_rate: grant=%0b rsn=%0d win=%0d required 0/3/2", r_grant, r_reason, win_count);
    end
  endtask

  task automatic test_backpressure();
    int k;
    apply_reset();
    allow0 = 32'h0000_0004; allow1 = 32'd0; policy_hash = 32'hABCD;
    rate_limit = 32'hFFFF_FFFF; rate_window = 32'd0; override_reg = 32'd0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_target = 6'd2; req_hash = 32'hABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; req_target = 6'd3; req_hash = 32'h0;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_grant !== 1'b1 || rsp_reason !== 2'd0 ||
          rsp_nonce !== 32'd1 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: vld=%0b grant=%0b rsn=%0d nonce=%h rdy=%0b required 1/1/0/1/0",
                 i, rsp_valid, rsp_grant, rsp_reason, rsp_nonce, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: vld=%0b rdy=%0b required 0/1", rsp_valid, req_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || nonce_val !== 32'd2) begin
      n_err++;
      $display("FAIL stall_no_phantom: vld=%0b nonce_val=%h required 0/2", rsp_valid, nonce_val);
    end
    do_req(6'd2, 32'hABCD);
    n_vec++;
    if (r_grant !== 1'b1 || r_nonce !== 32'd2) begin
      n_err++;
      $display("FAIL stall_next_req: grant=%0b nonce=%h required 1/2", r_grant, r_nonce);
    end
  endtask

  task automatic test_nonce_wrap_async_reset();
    int k;
    apply_reset();
    allow0 = 32'h0000_0004; policy_hash = 32'hABCD;
    rate_limit = 32'hFFFF_FFFF; rate_window = 32'd0; override_reg = 32'd0;
    do_req(6'd2, 32'hABCD);
    n_vec++;
    if (r_nonce_w !== 32'hFFFF_FFFF || nonce_val_w !== 32'd0) begin
      n_err++;
      $display("FAIL nonce_wrap: rsp_nonce=%h nonce_val=%h required FFFFFFFF/00000000", r_nonce_w, nonce_val_w);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_target = 6'd2; req_hash = 32'hABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      @(posedge clk); #1; k++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_valid_w !== 1'b0 || nonce_val !== 32'd1 || nonce_val_w !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL async_reset: vld=%0b vld_w=%0b nonce=%h nonce_w=%h required 0/0/1/FFFFFFFF",
               rsp_valid, rsp_valid_w, nonce_val, nonce_val_w);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_grant_deny();
    test_rate_window();
    test_override();
    test_backpressure();
    test_nonce_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
